// File: rtl/leb128_fetch_pkg.sv
// -----------------------------------------------------------------------------
// leb128_fetch_pkg
// Shared types and constants for the LEB128 operand-fetch stage and the
// block-type decoder that reuses leb128_byte_step.
//   leb_state_e : fetch FSM states
//   leb_err_e   : error codes reported on the err port
//   LEB_MAX32 / LEB_MAX64 : longest legal encodings in bytes
// -----------------------------------------------------------------------------
package leb128_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DECODE,
    ST_FINISH
  } leb_state_e;

  typedef enum logic [1:0] {
    LEB_OK       = 2'd0,
    LEB_MEM      = 2'd1,
    LEB_OVERLONG = 2'd2,
    LEB_RANGE    = 2'd3
  } leb_err_e;

  localparam int unsigned LEB_MAX32 = 5;
  localparam int unsigned LEB_MAX64 = 10;

  function automatic logic [3:0] leb_max_bytes(input logic is_64);
    return is_64 ? 4'(LEB_MAX64) : 4'(LEB_MAX32);
  endfunction

endpackage

// File: rtl/leb128_fetch_byte_step.sv
// -----------------------------------------------------------------------------
// leb128_byte_step
// Combinational single-byte LEB128 step.
//   acc_i/shift_i   : accumulator and bit position before this byte
//   byte_i          : encoded byte
//   is_64_i         : 1 = 64-bit immediate, 0 = 32-bit
//   is_signed_i     : 1 = varint, 0 = varuint
//   acc_o/shift_o   : raw accumulator and position after this byte
//   value_o         : acc_o sign-filled and extended to 64 bits (valid when last)
//   last_o          : continuation bit clear
//   range_ok_o      : final-byte payload fits the target width
// -----------------------------------------------------------------------------
module leb128_byte_step
  import leb128_fetch_pkg::*;
(
  input  logic [63:0] acc_i,
  input  logic [6:0]  shift_i,
  input  logic [7:0]  byte_i,
  input  logic        is_64_i,
  input  logic        is_signed_i,
  output logic [63:0] acc_o,
  output logic [63:0] value_o,
  output logic [6:0]  shift_o,
  output logic        last_o,
  output logic        range_ok_o
);

  logic [63:0] contrib;
  logic [63:0] fill;
  logic [63:0] ext;
  logic [6:0]  width;

  always_comb begin
    contrib = {57'd0, byte_i[6:0]} << shift_i;
    acc_o   = acc_i | contrib;
    shift_o = shift_i + 7'd7;
    last_o  = ~byte_i[7];
    width   = is_64_i ? 7'd64 : 7'd32;

    fill = '0;
    if (is_signed_i && (shift_o < width) && byte_i[6]) begin
      fill = {64{1'b1}} << shift_o;
    end
    ext = acc_o | fill;

    if (is_64_i) begin
      value_o = ext;
    end else if (is_signed_i) begin
      value_o = {{32{ext[31]}}, ext[31:0]};
    end else begin
      value_o = {32'd0, ext[31:0]};
    end

    // The maximal-length byte is identified by its starting shift
    // (28 for the 5th byte, 63 for the 10th).
    range_ok_o = 1'b1;
    if (!is_64_i && (shift_i == 7'd28)) begin
      if (is_signed_i) range_ok_o = (byte_i[6:3] == 4'h0) || (byte_i[6:3] == 4'hF);
      else             range_ok_o = (byte_i[6:4] == 3'd0);
    end else if (is_64_i && (shift_i == 7'd63)) begin
      if (is_signed_i) range_ok_o = (byte_i[6:0] == 7'h00) || (byte_i[6:0] == 7'h7F);
      else             range_ok_o = (byte_i[6:1] == 6'd0);
    end
  end

endmodule

// File: rtl/leb128_fetch.sv
// -----------------------------------------------------------------------------
// leb128_fetch
// Operand-fetch stage: reads a ROM window and decodes one LEB128 immediate.
//   clk, reset(active-low async)
//   start, pc_in, is_signed, is_64 : request (accepted while idle)
//   mem_addr, mem_extra            : ROM window request (mem_extra all-ones)
//   mem_data, mem_error            : ROM window response, valid the cycle after
//                                    mem_addr is registered
//   busy, done                     : status; done pulses for one cycle
//   value, next_pc, err            : result, held after done
// -----------------------------------------------------------------------------
module leb128_fetch
  import leb128_fetch_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 6,
  parameter int unsigned MEM_EXTRA = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [MEM_DEPTH:0]            pc_in,
  input  logic                          is_signed,
  input  logic                          is_64,
  output logic [MEM_DEPTH:0]            mem_addr,
  output logic [MEM_EXTRA-1:0]          mem_extra,
  input  logic [(2**MEM_EXTRA)*8-1:0]   mem_data,
  input  logic                          mem_error,
  output logic                          busy,
  output logic                          done,
  output logic [63:0]                   value,
  output logic [MEM_DEPTH:0]            next_pc,
  output logic [1:0]                    err
);

  localparam int unsigned AW = MEM_DEPTH + 1;
  localparam int unsigned WB = 2 ** MEM_EXTRA;

  leb_state_e            state_q, state_d;
  logic [AW-1:0]         pc_q, pc_d;
  logic                  sgn_q, sgn_d;
  logic                  w64_q, w64_d;
  logic [63:0]           acc_q, acc_d;
  logic [6:0]            shift_q, shift_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [WB*8-1:0]       win_q, win_d;
  logic [MEM_EXTRA-1:0]  idx_q, idx_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [63:0]           value_q, value_d;
  logic [AW-1:0]         npc_q, npc_d;
  leb_err_e              err_q, err_d;

  logic [7:0]  cur_byte;
  logic [3:0]  cnt_inc;
  logic [3:0]  max_cnt;
  logic        accept;
  logic [63:0] step_acc;
  logic [63:0] step_value;
  logic [6:0]  step_shift;
  logic        step_last;
  logic        step_range_ok;

  assign cur_byte = win_q[{idx_q, 3'b000} +: 8];
  assign cnt_inc  = cnt_q + 4'd1;
  assign max_cnt  = leb_max_bytes(w64_q);
  // The done cycle is already IDLE, so done_q blocks a start landing on it.
  assign accept   = (state_q == ST_IDLE) && start && !done_q;

  leb128_byte_step u_step (
    .acc_i       (acc_q),
    .shift_i     (shift_q),
    .byte_i      (cur_byte),
    .is_64_i     (w64_q),
    .is_signed_i (sgn_q),
    .acc_o       (step_acc),
    .value_o     (step_value),
    .shift_o     (step_shift),
    .last_o      (step_last),
    .range_ok_o  (step_range_ok)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_WAIT;
      ST_REQ:    state_d = ST_WAIT;
      ST_WAIT:   state_d = mem_error ? ST_FINISH : ST_DECODE;
      ST_DECODE: begin
        if (step_last || (cnt_inc == max_cnt)) state_d = ST_FINISH;
        else if (idx_q == '1)                  state_d = ST_REQ;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    pc_d    = pc_q;
    sgn_d   = sgn_q;
    w64_d   = w64_q;
    acc_d   = acc_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    value_d = value_q;
    npc_d   = npc_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          pc_d    = pc_in;
          sgn_d   = is_signed;
          w64_d   = is_64;
          addr_d  = pc_in;
          acc_d   = '0;
          shift_d = '0;
          cnt_d   = '0;
          err_d   = LEB_OK;
          busy_d  = 1'b1;
        end
      end
      ST_WAIT: begin
        win_d = mem_data;
        idx_d = '0;
        if (mem_error) err_d = LEB_MEM;
      end
      ST_DECODE: begin
        acc_d   = step_acc;
        shift_d = step_shift;
        cnt_d   = cnt_inc;
        idx_d   = idx_q + MEM_EXTRA'(1);
        if (step_last) begin
          // Out-of-range results keep the raw partial accumulator.
          if (step_range_ok) acc_d = step_value;
          else               err_d = LEB_RANGE;
        end else if (cnt_inc == max_cnt) begin
          err_d = LEB_OVERLONG;
        end else if (idx_q == '1) begin
          addr_d = pc_q + AW'(cnt_inc);
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        value_d = acc_q;
        npc_d   = pc_q + AW'(cnt_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      sgn_q   <= 1'b0;
      w64_q   <= 1'b0;
      acc_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      win_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      value_q <= '0;
      npc_q   <= '0;
      err_q   <= LEB_OK;
    end else begin
      pc_q    <= pc_d;
      sgn_q   <= sgn_d;
      w64_q   <= w64_d;
      acc_q   <= acc_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      value_q <= value_d;
      npc_q   <= npc_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_extra = '1;
  assign busy      = busy_q;
  assign done      = done_q;
  assign value     = value_q;
  assign next_pc   = npc_q;
  assign err       = err_q;

endmodule

// File: tb/tb_leb128_fetch.sv
// -----------------------------------------------------------------------------
// tb_leb128_fetch
// Scoreboard bench for leb128_fetch: instance A uses a 16-byte window,
// instance B a 4-byte window so refills and ROM bound errors are reachable.
// -----------------------------------------------------------------------------
module tb_leb128_fetch;

  localparam logic [1:0] E_OK = 2'd0, E_MEM = 2'd1, E_OVL = 2'd2, E_RNG = 2'd3;

  typedef struct {
    string       tag;
    logic [63:0] value;
    int          npc;
    logic [1:0]  err;
    int          lat;
    bit          cv;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0] rom [128];
  int ub_a = 255;
  int ub_b = 127;

  logic         start_a, sgn_a, w64_a, merr_a, busy_a, done_a;
  logic [6:0]   pc_a, addr_a, npc_a;
  logic [3:0]   extra_a;
  logic [127:0] data_a;
  logic [63:0]  value_a;
  logic [1:0]   err_a;

  logic         start_b, sgn_b, w64_b, merr_b, busy_b, done_b;
  logic [6:0]   pc_b, addr_b, npc_b;
  logic [1:0]   extra_b;
  logic [31:0]  data_b;
  logic [63:0]  value_b;
  logic [1:0]   err_b;

  always_comb begin
    data_a = '0;
    for (int k = 0; k < 16; k++) data_a[8*k +: 8] = rom[(int'(addr_a) + k) % 128];
    merr_a = (int'(addr_a) + 15) > ub_a;
  end

  always_comb begin
    data_b = '0;
    for (int k = 0; k < 4; k++) data_b[8*k +: 8] = rom[(int'(addr_b) + k) % 128];
    merr_b = (int'(addr_b) + 3) > ub_b;
  end

  leb128_fetch #(.MEM_DEPTH(6), .MEM_EXTRA(4)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .pc_in(pc_a), .is_signed(sgn_a),
    .is_64(w64_a), .mem_addr(addr_a), .mem_extra(extra_a), .mem_data(data_a),
    .mem_error(merr_a), .busy(busy_a), .done(done_a), .value(value_a),
    .next_pc(npc_a), .err(err_a)
  );

  leb128_fetch #(.MEM_DEPTH(6), .MEM_EXTRA(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .pc_in(pc_b), .is_signed(sgn_b),
    .is_64(w64_b), .mem_addr(addr_b), .mem_extra(extra_b), .mem_data(data_b),
    .mem_error(merr_b), .busy(busy_b), .done(done_b), .value(value_b),
    .next_pc(npc_b), .err(err_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Encoding bytes listed first-byte-first in the most significant n bytes.
  task automatic put(input int pc, input int n, input logic [79:0] bs);
    for (int i = 0; i < n; i++) rom[(pc + i) % 128] = bs[8*(n-1-i) +: 8];
  endtask

  function automatic logic busy_of(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  function automatic logic done_of(input bit sel);
    return sel ? done_b : done_a;
  endfunction

  task automatic drive_start(input bit sel, input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  // Counts cycles from the accepting edge until done is seen (bounded).
  task automatic wait_done(input bit sel, input bit poke, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (poke && lat == 1) begin
        drive_start(sel, 1'b1);
        if (sel) pc_b = '0; else pc_a = '0;
      end
      if (poke && lat == 2) drive_start(sel, 1'b0);
    end while (!done_of(sel) && lat < 200);
    drive_start(sel, 1'b0);
  endtask

  task automatic compare(input bit sel, input int lat);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 64'(sb_q.size()), 64'd1);
      return;
    end
    e = sb_q.pop_front();
    check_eq({e.tag, "_lat"}, 64'(lat), 64'(e.lat));
    if (e.cv) check_eq({e.tag, "_value"}, sel ? value_b : value_a, e.value);
    check_eq({e.tag, "_npc"}, 64'(sel ? npc_b : npc_a), 64'(e.npc % 128));
    check_eq({e.tag, "_err"}, 64'(sel ? err_b : err_a), 64'(e.err));
    check_eq({e.tag, "_busy_done"}, 64'(busy_of(sel)), 64'd0);
  endtask

  task automatic run_op(input bit sel, input string tag, input int pc, input bit sgn,
                        input bit w64, input logic [63:0] ev, input int enpc,
                        input logic [1:0] eerr, input int elat, input bit cv,
                        input bit poke, input bit again);
    exp_t e;
    int lat;
    e.tag = tag; e.value = ev; e.npc = enpc; e.err = eerr; e.lat = elat; e.cv = cv;
    sb_q.push_back(e);
    @(negedge clk);
    if (sel) begin pc_b = 7'(pc); sgn_b = sgn; w64_b = w64; end
    else     begin pc_a = 7'(pc); sgn_a = sgn; w64_a = w64; end
    drive_start(sel, 1'b1);
    @(posedge clk); #1;
    drive_start(sel, 1'b0);
    check_eq({tag, "_busy"}, 64'(busy_of(sel)), 64'd1);
    wait_done(sel, poke, lat);
    compare(sel, lat);
    if (again) begin
      // start raised during the done cycle: first edge ignored, next accepted
      drive_start(sel, 1'b1);
      @(posedge clk); #1;
      check_eq({tag, "_ignored"}, 64'(busy_of(sel)), 64'd0);
      sb_q.push_back(e);
      @(posedge clk); #1;
      drive_start(sel, 1'b0);
      check_eq({tag, "_reaccept"}, 64'(busy_of(sel)), 64'd1);
      wait_done(sel, 1'b0, lat);
      compare(sel, lat);
    end
    @(posedge clk); #1;
    check_eq({tag, "_pulse"}, 64'(done_of(sel)), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    for (int i = 0; i < 128; i++) rom[i] = 8'h00;
    reset = 1'b0;
    start_a = 0; pc_a = '0; sgn_a = 0; w64_a = 0;
    start_b = 0; pc_b = '0; sgn_b = 0; w64_b = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy",  64'(busy_a),  64'd0);
    check_eq("rst_done",  64'(done_a),  64'd0);
    check_eq("rst_value", value_a,      64'd0);
    check_eq("rst_npc",   64'(npc_a),   64'd0);
    check_eq("rst_err",   64'(err_a),   64'd0);
    check_eq("rst_addr",  64'(addr_a),  64'd0);
    check_eq("rst_extra_a", 64'(extra_a), 64'hF);
    check_eq("rst_extra_b", 64'(extra_b), 64'h3);
    reset = 1'b1;

    put(33, 1, 80'h03);
    put(40, 3, 80'hE58E26);
    put(50, 1, 80'h7F);
    put(60, 2, 80'h807F);
    put(70, 5, 80'h8080808080);
    put(80, 5, 80'hFFFFFFFF1F);
    put(90, 5, 80'h8080808078);
    put(100, 10, 80'hFFFFFFFFFFFFFFFFFF01);
    put(8, 6, 80'h808080808001);
    put(85, 5, 80'hFFFFFFFF0F);

    run_op(0, "u32_1b",   33, 0, 0, 64'd3,                  34,  E_OK,  3, 1, 0, 1);
    run_op(0, "u64_3b",   40, 0, 1, 64'd624485,             43,  E_OK,  5, 1, 0, 0);
    run_op(0, "s64_m1",   50, 1, 1, 64'hFFFFFFFFFFFFFFFF,   51,  E_OK,  3, 1, 0, 0);
    run_op(0, "s32_2b",   60, 1, 0, 64'hFFFFFFFFFFFFFF80,   62,  E_OK,  4, 1, 1, 0);
    run_op(0, "u32_ovl",  70, 0, 0, 64'd0,                  75,  E_OVL, 7, 1, 0, 0);
    run_op(0, "u32_rng",  80, 0, 0, 64'd0,                  85,  E_RNG, 7, 0, 0, 0);
    run_op(0, "u32_max",  85, 0, 0, 64'h00000000FFFFFFFF,   90,  E_OK,  7, 1, 0, 0);
    run_op(0, "s32_min",  90, 1, 0, 64'hFFFFFFFF80000000,   95,  E_OK,  7, 1, 0, 0);
    run_op(0, "u64_max", 100, 0, 1, 64'hFFFFFFFFFFFFFFFF,  110,  E_OK, 12, 1, 0, 0);

    run_op(1, "b_refill",  8, 0, 1, 64'h0000000800000000,   14,  E_OK, 10, 1, 0, 0);
    ub_b = 11;
    run_op(1, "b_memerr",  8, 0, 1, 64'd0,                  12,  E_MEM, 8, 1, 0, 0);
    ub_b = 127;

    // Abort a 64-bit decode mid-stream with an asynchronous reset.
    put(115, 5, 80'h8080808001);
    @(negedge clk);
    pc_a = 7'd115; sgn_a = 0; w64_a = 1; start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    repeat (3) @(posedge clk);
    #2;
    seen = done_a;
    reset = 1'b0;
    #1;
    check_eq("abort_busy",  64'(busy_a), 64'd0);
    check_eq("abort_done",  64'(done_a), 64'd0);
    check_eq("abort_value", value_a,     64'd0);
    check_eq("abort_npc",   64'(npc_a),  64'd0);
    check_eq("abort_err",   64'(err_a),  64'd0);
    check_eq("abort_addr",  64'(addr_a), 64'd0);
    repeat (3) begin @(posedge clk); #1; seen = seen | done_a; end
    reset = 1'b1;
    repeat (10) begin @(posedge clk); #1; seen = seen | done_a; end
    check_eq("abort_nodone", 64'(seen), 64'd0);

    put(112, 1, 80'h7F);
    run_op(0, "recover", 112, 0, 0, 64'd127, 113, E_OK, 3, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
